// File: rtl/head_tx_arb_if.sv
// Port bundle for head_tx_arb: client requests, length/gap inputs, port ROM
// handshake and the client control chain.
interface head_tx_arb_if #(
  parameter int unsigned jumbo_dw  = 14,
  parameter int unsigned n_clients = 16,
  parameter int unsigned sel_w     = 4
);
  logic [n_clients-1:0] tx_request;
  logic [jumbo_dw-1:0]  payload_len;
  logic [6:0]           gap_len;
  logic                 port_bsel;
  logic [sel_w:0]       port_addr;
  logic [7:0]           port_byte;
  logic [9:0]           out_c;
  logic                 busy;
  logic [sel_w-1:0]     client_sel;
  logic                 arp_mode;
  logic                 icmp_mode;

  modport master (
    input  tx_request, payload_len, gap_len, port_bsel, port_byte,
    output port_addr, out_c, busy, client_sel, arp_mode, icmp_mode
  );

  modport slave (
    output tx_request, payload_len, gap_len, port_bsel, port_byte,
    input  port_addr, out_c, busy, client_sel, arp_mode, icmp_mode
  );
endinterface

// File: rtl/head_tx_arb.sv
// Transmit head-end: arbitrates client requests and sequences one packet through
// PORT/LEN/HEAD/DATA/GAP. Define HEAD_TX_RR_EN for round-robin arbitration.
module head_tx_arb #(
  parameter int unsigned jumbo_dw    = 14,
  parameter int unsigned n_clients   = 16,
  parameter int unsigned sel_w       = 4,
  parameter int unsigned head_len    = 48,
  parameter int unsigned arp_client  = 7,
  parameter int unsigned icmp_client = 6,
  parameter int unsigned default_len = 18
) (
  input logic           clk,
  input logic           rst,
  head_tx_arb_if.master bus
);
  localparam int unsigned cnt_w = jumbo_dw + 1;

  typedef enum logic [7:0] {
    IDLE  = 8'b0000_0001,
    PORT1 = 8'b0000_0010,
    PORT2 = 8'b0000_0100,
    LEN1  = 8'b0000_1000,
    LEN2  = 8'b0001_0000,
    HEAD  = 8'b0010_0000,
    DATA  = 8'b0100_0000,
    GAP   = 8'b1000_0000
  } state_t;

  state_t           state, state_nxt;
  logic [cnt_w-1:0] cnt, cnt_nxt;
  logic             cnt_last;
  logic             grant;
  logic [sel_w-1:0] winner;
  logic [sel_w-1:0] client_sel, client_sel_nxt;
  logic [8:0]       out_lo, out_lo_nxt;
  logic             busy_q, busy_nxt;
  logic             arp_q, arp_nxt;
  logic             icmp_q, icmp_nxt;
  logic             port_hi;

  assign cnt_last = (cnt == cnt_w'(1));
  assign grant    = (state == IDLE) && (|bus.tx_request);

`ifdef HEAD_TX_RR_EN
  logic [sel_w-1:0] rr_ptr;
  logic [sel_w-1:0] rr_idx;

  // Search pointer+1 upward with wrap; iterating from the far end lets the nearest hit win.
  always_comb begin
    winner = '0;
    rr_idx = '0;
    for (int k = n_clients; k >= 1; k--) begin
      rr_idx = rr_ptr + sel_w'(k);
      if (bus.tx_request[rr_idx]) winner = rr_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= sel_w'(n_clients - 1);
    else if (grant) rr_ptr <= winner;
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    winner = '0;
    for (int i = n_clients - 1; i >= 0; i--) begin
      if (bus.tx_request[i]) winner = sel_w'(i);
    end
  end
`endif

  // Next-state, phase counter and registered-output precompute.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    client_sel_nxt = client_sel;
    port_hi        = 1'b0;
    out_lo_nxt     = '0;

    case (state)
      IDLE:  if (grant) begin
               state_nxt      = PORT1;
               client_sel_nxt = winner;
             end
      PORT1: state_nxt = PORT2;
      PORT2: state_nxt = LEN1;
      LEN1:  state_nxt = LEN2;
      LEN2:  begin
               state_nxt = HEAD;
               cnt_nxt   = cnt_w'(head_len);
             end
      HEAD:  if (cnt_last) begin
               state_nxt = DATA;
               cnt_nxt   = (bus.payload_len == '0) ? cnt_w'(1) : cnt_w'(bus.payload_len);
             end else begin
               cnt_nxt = cnt - cnt_w'(1);
             end
      DATA:  if (cnt_last) begin
               state_nxt = GAP;
               cnt_nxt   = (bus.gap_len == '0) ? cnt_w'(1) : cnt_w'(bus.gap_len);
             end else begin
               cnt_nxt = cnt - cnt_w'(1);
             end
      GAP:   if (cnt_last) begin
               state_nxt = IDLE;
               cnt_nxt   = cnt_w'(head_len);
             end else begin
               cnt_nxt = cnt - cnt_w'(1);
             end
      default: begin
               state_nxt = IDLE;
               cnt_nxt   = cnt_w'(head_len);
             end
    endcase

    if (state == HEAD || state == DATA) port_hi = bus.port_bsel;
    else if (state == PORT2)            port_hi = 1'b1;

    out_lo_nxt[8] = (state == PORT2);
    if (state == PORT1 || state == PORT2) out_lo_nxt[7:0] = bus.port_byte;
    else if (state == LEN2)               out_lo_nxt[7:0] = 8'(default_len);

    busy_nxt = (state_nxt != IDLE);
    arp_nxt  = (client_sel_nxt == sel_w'(arp_client));
    icmp_nxt = (client_sel_nxt == sel_w'(icmp_client));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= cnt_w'(head_len);
      client_sel <= '0;
      out_lo     <= '0;
      busy_q     <= 1'b0;
      arp_q      <= (sel_w'(arp_client) == sel_w'(0));
      icmp_q     <= (sel_w'(icmp_client) == sel_w'(0));
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      client_sel <= client_sel_nxt;
      out_lo     <= out_lo_nxt;
      busy_q     <= busy_nxt;
      arp_q      <= arp_nxt;
      icmp_q     <= icmp_nxt;
    end
  end

  // Mux control tracks the DATA flop directly so it falls with the state.
  assign bus.out_c      = {state == DATA, out_lo};
  assign bus.port_addr  = {client_sel, port_hi};
  assign bus.busy       = busy_q;
  assign bus.client_sel = client_sel;
  assign bus.arp_mode   = arp_q;
  assign bus.icmp_mode  = icmp_q;
endmodule

// File: tb/tb_head_tx_arb.sv
// Directed table-driven bench for head_tx_arb with hand sequences for reset,
// back-to-back arbitration and maximum payload length.
module tb_head_tx_arb;
  localparam int unsigned jumbo_dw  = 14;
  localparam int unsigned n_clients = 16;
  localparam int unsigned sel_w     = 4;
  localparam int          head_len  = 48;
`ifdef HEAD_TX_RR_EN
  localparam bit rr = 1'b1;
`else
  localparam bit rr = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  head_tx_arb_if #(.jumbo_dw(jumbo_dw), .n_clients(n_clients), .sel_w(sel_w)) bus ();

  head_tx_arb #(
    .jumbo_dw(jumbo_dw), .n_clients(n_clients), .sel_w(sel_w), .head_len(head_len),
    .arp_client(7), .icmp_client(6), .default_len(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] rom(input logic [sel_w:0] a);
    return 8'(a) * 8'd13 + 8'h21;
  endfunction

  assign bus.port_byte = rom(bus.port_addr);

  typedef struct {
    logic [15:0] req;
    int          plen;
    int          glen;
    int          sel_fp;
    int          sel_rr;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one request and follow the whole packet until the first IDLE cycle.
  task automatic run_pkt(input logic [15:0] req, input int plen, input int glen,
                         input int exp_sel, input bit hold);
    int dl, gl, total, first_data, last_data, data_cnt, first_idle;
    logic [sel_w-1:0] s;
    s  = sel_w'(exp_sel);
    dl = (plen == 0) ? 1 : plen;
    gl = (glen == 0) ? 1 : glen;
    total = 4 + head_len + dl + gl + 1;
    first_data = 0; last_data = 0; data_cnt = 0; first_idle = 0;
    bus.tx_request  = req;
    bus.payload_len = jumbo_dw'(plen);
    bus.gap_len     = 7'(glen);
    bus.port_bsel   = 1'b0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold) bus.tx_request = '0;
        check("grant_sel", 32'(bus.client_sel), 32'(exp_sel));
        check("arp_mode", 32'(bus.arp_mode), 32'(exp_sel == 7));
        check("icmp_mode", 32'(bus.icmp_mode), 32'(exp_sel == 6));
        check("busy_start", 32'(bus.busy), 32'd1);
      end
      if (k == 2) check("port_byte_lo", 32'(bus.out_c[8:0]), 32'({1'b0, rom({s, 1'b0})}));
      if (k == 3) check("port_byte_hi", 32'(bus.out_c[8:0]), 32'({1'b1, rom({s, 1'b1})}));
      if (k == 4) check("len1_byte", 32'(bus.out_c[8:0]), 32'd0);
      if (k == 5) check("len2_byte", 32'(bus.out_c[8:0]), 32'd18);
      if (k == 10) begin
        bus.port_bsel = 1'b1;
        #1;
        check("port_addr_head", 32'(bus.port_addr), 32'({s, 1'b1}));
        bus.port_bsel = 1'b0;
      end
      if (bus.out_c[9]) begin
        if (first_data == 0) first_data = k;
        last_data = k;
        data_cnt++;
      end
      if (!bus.busy && first_idle == 0) first_idle = k;
    end
    check("data_first", 32'(first_data), 32'(5 + head_len));
    check("data_cycles", 32'(data_cnt), 32'(dl));
    check("data_last", 32'(last_data), 32'(4 + head_len + dl));
    check("idle_cycle", 32'(first_idle), 32'(total));
  endtask

  initial begin
    tbl[0] = '{req: 16'h0001, plen: 20, glen: 13,  sel_fp: 0,  sel_rr: 0};
    tbl[1] = '{req: 16'h00C0, plen: 5,  glen: 3,   sel_fp: 6,  sel_rr: 6};
    tbl[2] = '{req: 16'h00C0, plen: 0,  glen: 0,   sel_fp: 6,  sel_rr: 7};
    tbl[3] = '{req: 16'h8000, plen: 1,  glen: 1,   sel_fp: 15, sel_rr: 15};
    tbl[4] = '{req: 16'h0A00, plen: 3,  glen: 127, sel_fp: 9,  sel_rr: 9};
    tbl[5] = '{req: 16'h0401, plen: 2,  glen: 4,   sel_fp: 0,  sel_rr: 10};

    rst = 1'b1;
    bus.tx_request  = '0;
    bus.payload_len = '0;
    bus.gap_len     = '0;
    bus.port_bsel   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_out_c", 32'(bus.out_c), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_client_sel", 32'(bus.client_sel), 32'd0);
    check("rst_arp", 32'(bus.arp_mode), 32'd0);
    check("rst_icmp", 32'(bus.icmp_mode), 32'd0);
    check("rst_port_addr", 32'(bus.port_addr), 32'd0);

    foreach (tbl[i]) begin
      run_pkt(tbl[i].req, tbl[i].plen, tbl[i].glen, rr ? tbl[i].sel_rr : tbl[i].sel_fp, 1'b0);
    end

    // Reset while in DATA, then a fresh packet.
    bus.tx_request  = 16'h0004;
    bus.payload_len = jumbo_dw'(30);
    bus.gap_len     = 7'd2;
    @(negedge clk);
    bus.tx_request = '0;
    check("mid_grant", 32'(bus.client_sel), 32'd2);
    repeat (59) @(negedge clk);
    check("mid_in_data", 32'(bus.out_c[9]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_c", 32'(bus.out_c), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sel", 32'(bus.client_sel), 32'd0);
    run_pkt(16'h0008, 4, 2, 3, 1'b0);

    // All clients held requesting across 17 back-to-back packets.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      run_pkt(16'hFFFF, 0, 0, rr ? (i % 16) : 0, 1'b1);
    end
    bus.tx_request = '0;

    run_pkt(16'h0002, 16383, 1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/head_tx_arb.md
# head_tx_arb

Parametrised transmit head-end for the UDP client chain. Arbitrates among `n_clients` transmit requests and sequences one packet at a time through port, length, header, data and inter-frame-gap phases. Drives the client control chain `out_c` and supplies the selected client's UDP source port to Ethernet packet assembly through an external port ROM. Differences from the fixed 16-client head-end:

- synchronous reset
- runtime-programmable gap
- parametrised header length and client count
- optional round-robin arbitration

## Interface
- `jumbo_dw`, 14, payload length width (14 jumbo, 11 standard)
- `n_clients`, 16, number of request inputs; power of two, 2..64
- `sel_w`, 4, log2(`n_clients`)
- `head_len`, 48, HEAD phase length in cycles; must match the assembler's header-processing phase
- `arp_client`, 7, client index flagged by `arp_mode`
- `icmp_client`, 6, client index flagged by `icmp_mode`
- `default_len`, 18, length byte driven during LEN2

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `tx_request`  in  `n_clients`  per-client packet request, level
- `payload_len`  in  `jumbo_dw`  payload length from tail end
- `gap_len`  in  7  GAP phase length in cycles; 0 is treated as 1
- `port_bsel`  in  1  port byte select from assembler, used in HEAD/DATA
- `port_addr`  out  `sel_w`+1  external port ROM address {client_sel, port_hi}
- `port_byte`  in  8  port ROM data, combinational from `port_addr`
- `out_c`  out  10  client chain: [9] mux control, [8] port strobe, [7:0] byte
- `busy`  out  1  high whenever the state is not IDLE
- `client_sel`  out  `sel_w`  latched winning client
- `arp_mode`  out  1  `client_sel` == `arp_client`
- `icmp_mode`  out  1  `client_sel` == `icmp_client`

## Operation
- One-hot FSM with states IDLE, PORT1, PORT2, LEN1, LEN2, HEAD, DATA, GAP.
- IDLE: when any `tx_request` bit is set, latch the winner into `client_sel` and go to PORT1.
- PORT1 → PORT2 → LEN1 → LEN2 → HEAD each take one cycle.
- HEAD lasts exactly `head_len` cycles, then goes to DATA.
- DATA lasts `payload_len` cycles, then goes to GAP.
  - `payload_len` is sampled in the last HEAD cycle.
  - `payload_len` = 0 gives 1 DATA cycle.
- GAP lasts `gap_len` cycles, then returns to IDLE.
  - `gap_len` is sampled in the last DATA cycle.
- Phase counters are `jumbo_dw`+1 bits wide and count down. Each phase exits when its counter is 1. Counters never wrap.
- `port_hi`:
  - equals `port_bsel` in HEAD or DATA
  - 1 in PORT2
  - 0 otherwise
- Arbitration: fixed priority, lowest index wins.
- Requests are ignored outside IDLE. A request dropped mid-packet does not abort the packet.
- `arp_mode` and `icmp_mode` are combinational from `client_sel` and hold until the next grant.

## Timing
- `out_c[9]` is combinational and equals the DATA state.
- `out_c[8:0]` is registered, one cycle after state:
  - `out_c[8]` = registered PORT2
  - `out_c[7:0]` = registered (PORT1|PORT2 ? `port_byte` : LEN2 ? `default_len` : 0)
- Packet cycles from grant to IDLE: 4 + `head_len` + max(`payload_len`,1) + max(`gap_len`,1) + 1.
- Minimum request-to-PORT1 latency is 1 cycle.
- Back-to-back packets: the earliest next grant is in the first IDLE cycle after GAP.
- Reset values:
  - state IDLE
  - `client_sel` = 0
  - `out_c` = 0
  - `busy` = 0
  - all counters at load values
- `arp_mode` and `icmp_mode` after reset reflect `client_sel` = 0.
- Reset mid-packet: IDLE on the next edge. `out_c[9]` drops in the same cycle as the state change. `out_c[8:0]` = 0 after that edge.

## Configuration
- `HEAD_TX_RR_EN` defined: round-robin arbitration.
  - A rotating pointer records the last granted index.
  - The search starts at pointer+1 and wraps modulo `n_clients`.
  - The pointer resets to `n_clients`-1, so the first grant after reset favours index 0.
- `HEAD_TX_RR_EN` undefined: fixed priority, lowest index wins; no pointer logic.

## Test plan
- Reset, then `tx_request`=0x0001, `payload_len`=20, `gap_len`=13 → `out_c[8:0]` carries ROM addr {0,0} then {0,1} bytes with bit 8 on the second; LEN2+1 cycle byte = 18; `out_c[9]` high for exactly 20 cycles starting 53 cycles after grant; `busy` low 86 cycles after grant.
- `tx_request`=0x00C0 (clients 6,7) → `client_sel`=6 and `icmp_mode`=1; with `HEAD_TX_RR_EN`, the next packet grants 7 with `arp_mode`=1.
- With `HEAD_TX_RR_EN` and `tx_request`=0xFFFF held for 17 packets → grant order 0,1,…,15,0. Without the macro → all grants to 0.
- `payload_len`=0 and `gap_len`=0 → DATA 1 cycle, GAP 1 cycle; no counter wrap.
- Assert `rst` for 1 cycle in DATA → `out_c[9]`=0 and `busy`=0 after the edge; a new request then follows the normal sequence from PORT1.
- `payload_len`=16383, `jumbo_dw`=14 → DATA lasts exactly 16383 cycles.
